// File: rtl/nibble_sub_sched_if.sv
// Request/result bundle for the shared nibble-serial subtractor.
interface nibble_sub_sched_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_diff;
  logic             res_borrow;
  logic             res_id;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, res_valid, res_diff, res_borrow, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_diff, res_borrow, res_id, busy
  );
endinterface

// File: rtl/nibble_sub_sched.sv
// Two-requester round-robin scheduler around one 4-bit borrow-chained subtract
// stage; each WIDTH-bit subtract runs LSB nibble first, one nibble per clock.
module nibble_sub_sched #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  nibble_sub_sched_if.slave bus
);
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned SW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             bin_q;
  logic [IW-1:0]    idx_q;
  logic             id_q;
  logic             rr_last;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_diff_q;
  logic             res_borrow_q;
  logic             res_id_q;
  logic             busy_q;

  logic             rdy0;
  logic             rdy1;
  logic [SW-1:0]    lo;
  logic [4:0]       sub5;
  logic [WIDTH-1:0] diff_nx;

  // Grant logic: only in IDLE, and held low while reset is asserted.
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (rst_n && state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        rdy0 = rr_last;
        rdy1 = ~rr_last;
      end else begin
        rdy0 = bus.req0_valid;
        rdy1 = bus.req1_valid;
      end
    end
  end

  // One nibble of the borrow chain, merged into the working difference.
  always_comb begin
    lo      = SW'({idx_q, 2'b00});
    sub5    = {1'b0, a_q[lo +: 4]} - {1'b0, b_q[lo +: 4]} - {4'b0000, bin_q};
    diff_nx = diff_q;
    diff_nx[lo +: 4] = sub5[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      bin_q        <= 1'b0;
      idx_q        <= '0;
      id_q         <= 1'b0;
      rr_last      <= 1'b1;
      res_valid_q  <= 1'b0;
      res_diff_q   <= '0;
      res_borrow_q <= 1'b0;
      res_id_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rdy0 || rdy1) begin
            a_q     <= rdy1 ? bus.req1_a : bus.req0_a;
            b_q     <= rdy1 ? bus.req1_b : bus.req0_b;
            id_q    <= rdy1;
            rr_last <= rdy1;
            bin_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          diff_q <= diff_nx;
          bin_q  <= sub5[4];
          idx_q  <= idx_q + IW'(1);
          if (idx_q == IW'(NIB - 1)) begin
            res_valid_q  <= 1'b1;
            res_diff_q   <= diff_nx;
            res_borrow_q <= sub5[4];
            res_id_q     <= id_q;
            state        <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_diff   = res_diff_q;
  assign bus.res_borrow = res_borrow_q;
  assign bus.res_id     = res_id_q;
  assign bus.busy       = busy_q;
endmodule
